led8_bcd_7seg_scan: RTL and testbench
=====================================

// Module: led8_bcd_7seg_scan
// PURPOSE
//  Display-side consumer of the 8-bit LED counter bus (LED8_OUT of the counter top).
//  Converts the 8-bit binary value to 3 BCD digits with a sequential double-dabble FSM.
//  Drives a 3-digit multiplexed common-anode 7-segment display from the 50 MHz board clock.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency in Hz
//  SCAN_HZ  1_000       digit-advance rate in Hz; prescaler terminal = CLK_HZ/SCAN_HZ-1 (must be >= 1)
// PORTS
//  Clk50MHz  in   1  system clock, all logic on rising edge
//  RST       in   1  synchronous reset, active-low
//  VAL_IN    in   8  binary value to display (0..255), e.g. the counter's LED8_OUT
//  SEG_OUT   out  7  segments {g,f,e,d,c,b,a}, active-low
//  AN_OUT    out  3  digit anodes, active-low; [0]=units, [1]=tens, [2]=hundreds
//  BUSY      out  1  high while a conversion is in progress
// BEHAVIOUR
//  Reset (RST=0 at an edge): SEG_OUT=7'h7F, AN_OUT=3'b111, BUSY=0, state=IDLE,
//   last_val=0, digit regs H/T/U=0, prescaler=0, scan index=0. Synchronous reset overrides all.
//  Converter FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: at edge k, if VAL_IN != last_val: capture VAL_IN, clear 12-bit BCD acc, shift cnt=0,
//    BUSY<=1, -> SHIFT. Otherwise stay idle, BUSY=0.
//   SHIFT: one bit per edge, MSB first; before each shift, add 3 to every BCD nibble >= 5.
//    Exactly 8 edges (k+1..k+8); after the 8th -> DONE.
//   DONE (edge k+9): H/T/U <= acc, last_val <= captured value, BUSY<=0, -> IDLE.
//   Latency: VAL_IN change sampled at edge k is visible in digit regs after edge k+9.
//   VAL_IN changes during SHIFT/DONE are ignored; re-detected on the next IDLE edge.
//   Back-to-back changes are therefore re-sampled every 10 cycles; the last value always wins.
//  Arithmetic: acc is 12 bits, no overflow possible (max 255 -> 2/5/5). Nibbles stay 0..9.
//  Scan: prescaler counts 0..CLK_HZ/SCAN_HZ-1; on terminal count it wraps to 0 and
//   the scan index advances 0->1->2->0 (index 3 unreachable; if reached, go to 0).
//   AN_OUT and SEG_OUT are registered and updated together on every edge from the
//   current scan index and digit regs: AN_OUT has the single low bit at the index.
//  Segment codes (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//  Digit regs update mid-scan are allowed; the next registered SEG_OUT shows the new digit.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: hundreds digit blanked (SEG_OUT=7F while selected)
//   when H=0; tens blanked when H=0 and T=0. Units is never blanked. AN_OUT unchanged.
//  Not defined: all three digits always shown, including leading zeros (e.g. "007").
// TESTING  (sim with CLK_HZ=100, SCAN_HZ=10 -> index advances every 10 cycles)
//  1. Hold RST=0 for 3 edges -> SEG_OUT=7F, AN_OUT=111, BUSY=0; release, VAL_IN=0 ->
//     scan cycles AN_OUT 110,101,011 with SEG_OUT=40 each (macro off).
//  2. VAL_IN 0->255 at edge k -> BUSY=1 edges k..k+8, BUSY=0 after k+9; digits show
//     U=5 (12), T=5 (12), H=2 (24) on respective anodes.
//  3. VAL_IN=128, then changed to 9 at edge k+4 -> first result 1/2/8 after k+9;
//     BUSY re-asserts at k+10; final digits 0/0/9 after k+19.
//  4. Apply RST=0 mid-SHIFT (edge k+3) -> next edge all outputs at reset values,
//     BUSY=0; after release a new conversion of the current VAL_IN starts.
//  5. With LEADING_ZERO_BLANK_EN, VAL_IN=7 -> hundreds and tens SEG_OUT=7F, units=78;
//     VAL_IN=40 -> hundreds 7F, tens 19, units 40.
//  6. Run >=40 scan periods with constant VAL_IN=100 -> AN_OUT never 111 or multi-low
//     after reset release, each digit held exactly 10 cycles, codes 79/40/40.

Source files
------------

// File: rtl/led8_bcd_7seg_scan.sv
// 8-bit binary to 3-digit BCD (sequential double-dabble) with a multiplexed common-anode 7-seg driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
module led8_bcd_7seg_scan #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int SCAN_HZ = 1_000
) (
   input  logic       Clk50MHz,
   input  logic       RST,
   input  logic [7:0] VAL_IN,
   output logic [6:0] SEG_OUT,
   output logic [2:0] AN_OUT,
   output logic       BUSY
);

   localparam int TERM = CLK_HZ / SCAN_HZ - 1;
   localparam int PW   = (TERM < 1) ? 1 : $clog2(TERM + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [7:0]      last_val_q, last_val_d;
   logic [7:0]      cap_q, cap_d;
   logic [11:0]     acc_q, acc_d;
   logic [11:0]     acc_adj;
   logic [2:0]      cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic [3:0]      h_q, h_d, t_q, t_d, u_q, u_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      digit;
   logic [6:0]      seg_q, seg_d;
   logic [2:0]      an_q, an_d;

   function automatic logic [3:0] adj3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // Converter: one bit per SHIFT cycle, MSB first, nibbles corrected before each shift.
   always_comb begin
      state_d    = state_q;
      last_val_d = last_val_q;
      cap_d      = cap_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      h_d        = h_q;
      t_d        = t_q;
      u_d        = u_q;
      acc_adj    = {adj3(acc_q[11:8]), adj3(acc_q[7:4]), adj3(acc_q[3:0])};
      case (state_q)
         S_IDLE: begin
            if (VAL_IN != last_val_q) begin
               cap_d   = VAL_IN;
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end else begin
               busy_d = 1'b0;
            end
         end
         S_SHIFT: begin
            acc_d = {acc_adj[10:0], cap_q[3'd7 - cnt_q]};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = S_DONE;
         end
         S_DONE: begin
            h_d        = acc_q[11:8];
            t_d        = acc_q[7:4];
            u_d        = acc_q[3:0];
            last_val_d = cap_q;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Scan: anode and segment outputs are registered together from the current index.
   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PW'(TERM)) begin
         presc_d = '0;
         idx_d   = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
      case (idx_q)
         2'd1:    begin digit = t_q; an_d = 3'b101; end
         2'd2:    begin digit = h_q; an_d = 3'b011; end
         default: begin digit = u_q; an_d = 3'b110; end
      endcase
      seg_d = seg_of(digit);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_q == 2'd2 && h_q == 4'd0) seg_d = 7'h7F;
      if (idx_q == 2'd1 && h_q == 4'd0 && t_q == 4'd0) seg_d = 7'h7F;
`endif
   end

   // NOTE: reset is synchronous here, so it sits inside the clocked branch; state uses <= only.
   always_ff @(posedge Clk50MHz) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         last_val_q <= '0;
         cap_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         h_q        <= '0;
         t_q        <= '0;
         u_q        <= '0;
         presc_q    <= '0;
         idx_q      <= '0;
         seg_q      <= 7'h7F;
         an_q       <= 3'b111;
      end else begin
         state_q    <= state_d;
         last_val_q <= last_val_d;
         cap_q      <= cap_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         h_q        <= h_d;
         t_q        <= t_d;
         u_q        <= u_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign SEG_OUT = seg_q;
   assign AN_OUT  = an_q;
   assign BUSY    = busy_q;

endmodule

// File: tb/tb_led8_bcd_7seg_scan.sv
// Directed bench for led8_bcd_7seg_scan (CLK_HZ=100, SCAN_HZ=10 -> 10 cycles per digit).
module tb_led8_bcd_7seg_scan;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] val_in = 8'd0;
   logic [6:0] seg_out;
   logic [2:0] an_out;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   led8_bcd_7seg_scan #(.CLK_HZ(100), .SCAN_HZ(10)) dut (
      .Clk50MHz (clk),
      .RST      (rst_n),
      .VAL_IN   (val_in),
      .SEG_OUT  (seg_out),
      .AN_OUT   (an_out),
      .BUSY     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observe one full scan cycle and record the segment code shown on each anode.
   task automatic scan_capture(output logic [6:0] su, output logic [6:0] st,
                               output logic [6:0] sh, output bit ok);
      logic [2:0] seen;
      seen = 3'b000;
      su = 'x; st = 'x; sh = 'x;
      for (int i = 0; i < 32; i++) begin
         tick();
         case (an_out)
            3'b110: begin su = seg_out; seen[0] = 1'b1; end
            3'b101: begin st = seg_out; seen[1] = 1'b1; end
            3'b011: begin sh = seg_out; seen[2] = 1'b1; end
            default: ;
         endcase
      end
      ok = &seen;
   endtask

   // Apply a value from idle and wait out the fixed 10-edge conversion.
   task automatic convert(input logic [7:0] v, output bit done);
      val_in = v;
      for (int i = 0; i < 10; i++) tick();
      done = (busy === 1'b0);
   endtask

   task automatic cmp_digits(input string name, input logic [6:0] su, input logic [6:0] st,
                             input logic [6:0] sh, input logic [6:0] eu, input logic [6:0] et,
                             input logic [6:0] eh);
      n_cmp++;
      if (su !== eu) begin n_err++; $display("FAIL %s_units: got %h want %h", name, su, eu); end
      n_cmp++;
      if (st !== et) begin n_err++; $display("FAIL %s_tens: got %h want %h", name, st, et); end
      n_cmp++;
      if (sh !== eh) begin n_err++; $display("FAIL %s_hundreds: got %h want %h", name, sh, eh); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      val_in = 8'd0;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++;
      if (seg_out !== 7'h7F) begin n_err++; $display("FAIL reset_seg: got %h want 7f", seg_out); end
      n_cmp++;
      if (an_out !== 3'b111) begin n_err++; $display("FAIL reset_an: got %b want 111", an_out); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n = 1'b1;
   endtask

   task automatic test_scan_zero();
      logic [6:0] su, st, sh;
      bit ok;
      scan_capture(su, st, sh, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL zero_scan_seen: got 0 want 1"); end
`ifdef LEADING_ZERO_BLANK_EN
      cmp_digits("zero", su, st, sh, 7'h40, 7'h7F, 7'h7F);
`else
      cmp_digits("zero", su, st, sh, 7'h40, 7'h40, 7'h40);
`endif
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", busy); end
   endtask

   task automatic test_convert_255();
      logic [6:0] su, st, sh;
      bit ok;
      val_in = 8'd255;
      for (int i = 0; i < 9; i++) begin
         tick();
         n_cmp++;
         if (busy !== 1'b1) begin n_err++; $display("FAIL c255_busy_k%0d: got %b want 1", i, busy); end
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL c255_busy_end: got %b want 0", busy); end
      scan_capture(su, st, sh, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL c255_scan_seen: got 0 want 1"); end
      cmp_digits("c255", su, st, sh, 7'h12, 7'h12, 7'h24);
   endtask

   task automatic test_back_to_back();
      logic [6:0] su, st, sh, exp_seg;
      bit ok;
      val_in = 8'd128;
      for (int i = 0; i < 4; i++) tick();      // edges k..k+3
      val_in = 8'd9;                            // sampled at k+4, ignored
      for (int i = 0; i < 6; i++) tick();      // edges k+4..k+9
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_k9: got %b want 0", busy); end
      tick();                                   // edge k+10
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_k10: got %b want 1", busy); end
      case (an_out)
         3'b110:  exp_seg = 7'h00;
         3'b101:  exp_seg = 7'h24;
         3'b011:  exp_seg = 7'h79;
         default: exp_seg = 7'h7F;
      endcase
      n_cmp++;
      if (an_out !== 3'b110 && an_out !== 3'b101 && an_out !== 3'b011) begin
         n_err++; $display("FAIL b2b_an_k10: got %b want single low bit", an_out);
      end
      n_cmp++;
      if (seg_out !== exp_seg) begin n_err++; $display("FAIL b2b_first_result: got %h want %h", seg_out, exp_seg); end
      for (int i = 0; i < 9; i++) tick();      // edges k+11..k+19
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_k19: got %b want 0", busy); end
      scan_capture(su, st, sh, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL b2b_scan_seen: got 0 want 1"); end
`ifdef LEADING_ZERO_BLANK_EN
      cmp_digits("b2b", su, st, sh, 7'h10, 7'h7F, 7'h7F);
`else
      cmp_digits("b2b", su, st, sh, 7'h10, 7'h40, 7'h40);
`endif
   endtask

   task automatic test_reset_mid_shift();
      logic [6:0] su, st, sh;
      bit ok;
      val_in = 8'd77;
      for (int i = 0; i < 3; i++) tick();      // edges k..k+2
      rst_n = 1'b0;
      tick();                                   // edge k+3
      n_cmp++;
      if (seg_out !== 7'h7F) begin n_err++; $display("FAIL mid_rst_seg: got %h want 7f", seg_out); end
      n_cmp++;
      if (an_out !== 3'b111) begin n_err++; $display("FAIL mid_rst_an: got %b want 111", an_out); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      tick();                                   // edge k+4: restart
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL mid_rst_restart: got %b want 1", busy); end
      for (int i = 0; i < 9; i++) tick();
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_done: got %b want 0", busy); end
      scan_capture(su, st, sh, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL mid_rst_scan_seen: got 0 want 1"); end
`ifdef LEADING_ZERO_BLANK_EN
      cmp_digits("mid_rst", su, st, sh, 7'h78, 7'h78, 7'h7F);
`else
      cmp_digits("mid_rst", su, st, sh, 7'h78, 7'h78, 7'h40);
`endif
   endtask

   task automatic test_leading_zeros();
      logic [6:0] su, st, sh;
      bit ok, done;
      convert(8'd7, done);
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL lz7_done: got busy %b want 0", busy); end
      scan_capture(su, st, sh, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL lz7_scan_seen: got 0 want 1"); end
`ifdef LEADING_ZERO_BLANK_EN
      cmp_digits("lz7", su, st, sh, 7'h78, 7'h7F, 7'h7F);
`else
      cmp_digits("lz7", su, st, sh, 7'h78, 7'h40, 7'h40);
`endif
      convert(8'd40, done);
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL lz40_done: got busy %b want 0", busy); end
      scan_capture(su, st, sh, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL lz40_scan_seen: got 0 want 1"); end
`ifdef LEADING_ZERO_BLANK_EN
      cmp_digits("lz40", su, st, sh, 7'h40, 7'h19, 7'h7F);
`else
      cmp_digits("lz40", su, st, sh, 7'h40, 7'h19, 7'h40);
`endif
   endtask

   task automatic test_scan_stable();
      logic [2:0] prev_an, exp_next;
      logic [6:0] exp_seg;
      int run, n_runs, bad_an, bad_seg, bad_len, bad_ord;
      bit first, done;
      convert(8'd100, done);
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL s100_done: got busy %b want 0", busy); end
      tick();
      prev_an = an_out;
      run = 1; n_runs = 0; first = 1'b1;
      bad_an = 0; bad_seg = 0; bad_len = 0; bad_ord = 0;
      for (int i = 0; i < 420; i++) begin
         tick();
         case (an_out)
            3'b110:  exp_seg = 7'h40;
            3'b101:  exp_seg = 7'h40;
            3'b011:  exp_seg = 7'h79;
            default: begin exp_seg = 7'h7F; bad_an++; end
         endcase
         if (seg_out !== exp_seg) bad_seg++;
         if (an_out === prev_an) begin
            run++;
         end else begin
            case (prev_an)
               3'b110:  exp_next = 3'b101;
               3'b101:  exp_next = 3'b011;
               default: exp_next = 3'b110;
            endcase
            if (an_out !== exp_next) bad_ord++;
            if (!first) begin
               n_runs++;
               if (run != 10) bad_len++;
            end
            first = 1'b0;
            run = 1;
            prev_an = an_out;
         end
      end
      n_cmp++;
      if (bad_an != 0) begin n_err++; $display("FAIL s100_an_onehot: got %0d bad cycles want 0", bad_an); end
      n_cmp++;
      if (bad_seg != 0) begin n_err++; $display("FAIL s100_seg: got %0d bad cycles want 0", bad_seg); end
      n_cmp++;
      if (bad_len != 0) begin n_err++; $display("FAIL s100_dwell: got %0d bad runs want 0", bad_len); end
      n_cmp++;
      if (bad_ord != 0) begin n_err++; $display("FAIL s100_order: got %0d bad steps want 0", bad_ord); end
      n_cmp++;
      if (n_runs < 40) begin n_err++; $display("FAIL s100_runs: got %0d want >= 40", n_runs); end
   endtask

   initial begin
      test_reset();
      test_scan_zero();
      test_convert_255();
      test_back_to_back();
      test_reset_mid_shift();
      test_leading_zeros();
      test_scan_stable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
